// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit stage.
// Optional macro UART_TX_PARITY_EN adds the even-parity state.
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with a registered occupancy count.
// Push while full and pop while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stage.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser with registered tx.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before STOP).
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  state_t                 state, state_next;
  logic [BAUD_W-1:0]      baud_cnt, baud_next;
  logic [BIT_W-1:0]       bit_idx, bit_next;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   tx_next;
  logic                   bit_end;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_head;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_next;
`endif

  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign bit_end   = (baud_cnt == BAUD_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_q;
`endif
    if (state != ST_IDLE) baud_next = bit_end ? '0 : baud_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_next = shreg >> 1;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next frame so back-to-back bytes leave no idle gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (fifo_pop) begin
      shreg_next = fifo_head;
`ifdef UART_TX_PARITY_EN
      parity_next = even_parity(fifo_head);
`endif
    end

    // tx is registered from the next state so the line changes on the same edge as the state.
    case (state_next)
      ST_START:  tx_next = START_BIT;
      ST_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= STOP_BIT;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= shreg_next;
      tx       <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_next;
  end
`endif

endmodule

// File: tb/tb_uart_tx_stage.sv
// Self-checking bench for uart_tx_stage: table-driven frames, directed corner
// sequences and randomized traffic against a queue-based line model.
module tb_uart_tx_stage;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FL = FRAME_BITS * CPB;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     tx;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Model: bytes waiting in the FIFO, and the per-cycle line levels of the frame in flight.
  logic [7:0] fifo_q[$];
  bit         line_q[$];
  logic       acc;

  uart_tx_stage #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void load_frame(logic [7:0] b);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[j]) repeat (CPB) line_q.push_back(bits[j]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      line_q.delete();
    end else begin
      acc = in_valid && (fifo_q.size() < DEPTH);
      if (line_q.size() != 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && fifo_q.size() != 0) load_frame(fifo_q.pop_front());
      if (acc) fifo_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_tx", tx, (line_q.size() != 0) ? line_q[0] : 1'b1);
      check("model_busy", busy, line_q.size() != 0);
      check("model_fifo_count", fifo_count, fifo_q.size());
      check("model_in_ready", in_ready, (fifo_q.size() < DEPTH) && !rst);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy !== 1'b0 || fifo_count !== '0) && t < 2000) begin
      cyc(1);
      t++;
    end
    check("idle_timeout", t < 2000, 1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // line levels, bit 0 = first bit on the wire
  } vec_t;

  vec_t vecs[5];
  int   acc_n, peak, edges, gap;

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 11'b1_0_01010101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{8'h03, 11'b1_0_00000011_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{8'h80, 11'b1_1_10000000_0};
`else
    vecs[0] = '{8'h55, 11'b0_1_01010101_0};
    vecs[1] = '{8'h07, 11'b0_1_00000111_0};
    vecs[2] = '{8'h03, 11'b0_1_00000011_0};
    vecs[3] = '{8'hFF, 11'b0_1_11111111_0};
    vecs[4] = '{8'h80, 11'b0_1_10000000_0};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    cyc(1);
    check_en = 1'b1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("post_rst_in_ready", in_ready, 1);

    // Single frames from the vector table
    foreach (vecs[v]) begin
      wait_idle();
      in_data = vecs[v].data; in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      check("pre_start_tx", tx, 1);
      check("pre_start_count", fifo_count, 1);
      cyc(1);
      for (int k = 0; k < FL; k++) begin
        check($sformatf("vec%0d_bit%0d", v, k / CPB), tx, vecs[v].frame[k / CPB]);
        check("frame_busy", busy, 1);
        cyc(1);
      end
      check("frame_end_tx", tx, 1);
      check("frame_end_busy", busy, 0);
    end

    // Six bytes offered back to back into a 4-deep FIFO
    wait_idle();
    acc_n = 0; peak = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i + 1); in_valid = 1'b1;
      if (in_ready) acc_n++;
      cyc(1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("burst_accepted", acc_n, 5);
    check("burst_peak", peak, 4);
    edges = 6;
    while (!in_ready && edges < 500) begin
      cyc(1);
      edges++;
    end
    check("sixth_accept_edge", edges + 1, FL + 3);
    cyc(1);
    in_valid = 1'b0;

    // Two queued bytes must chain with no idle cycle
    wait_idle();
    in_data = 8'hA5; in_valid = 1'b1;
    cyc(1);
    in_data = 8'h3C;
    cyc(1);
    in_valid = 1'b0;
    check("b2b_first_start", tx, 0);
    gap = 0;
    for (int k = 1; k <= FL; k++) begin
      cyc(1);
      if (busy !== 1'b1) gap++;
      if (k == FL - 1) check("b2b_stop", tx, 1);
    end
    check("b2b_second_start", tx, 0);
    check("b2b_idle_cycles", gap, 0);

    // Reset pulse during D3 of 0xFF with two bytes queued
    wait_idle();
    in_data = 8'hFF; in_valid = 1'b1;
    cyc(1);
    in_data = 8'h11;
    cyc(1);
    in_data = 8'h22;
    cyc(1);
    in_valid = 1'b0;
    cyc(15);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_count", fifo_count, 2);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    cyc(1);
    check("after_rst_in_ready", in_ready, 1);
    check("after_rst_busy", busy, 0);
    cyc(FL);
    check("discarded_tx", tx, 1);
    check("discarded_busy", busy, 0);

    // Push and pop on the same edge with two bytes queued
    wait_idle();
    in_data = 8'h81; in_valid = 1'b1;
    cyc(1);
    in_data = 8'h42;
    cyc(1);
    in_data = 8'h24;
    cyc(1);
    in_valid = 1'b0;
    check("pp_count_before", fifo_count, 2);
    cyc(FL - 2);
    check("pp_busy", busy, 1);
    check("pp_count_pre", fifo_count, 2);
    in_data = 8'h18; in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    check("pp_count_same", fifo_count, 2);
    check("pp_next_start", tx, 0);
    wait_idle();

    // Randomized traffic with varying load and occasional resets
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 500; c++) begin
        in_valid = ($urandom_range(0, 3) < (seg % 4));
        in_data  = 8'($urandom);
        rst      = ($urandom_range(0, 599) == 0);
        cyc(1);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    wait_idle();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
